// File: rtl/pulse_measure_multi_pkg.sv
// ============================================================================
// pulse_measure_multi_pkg
// Shared flag layout and record helpers for the pulse meter and its consumers.
// Revision: 1.0
// ============================================================================
`default_nettype none

package pulse_measure_multi_pkg;

   localparam int PM_FLAG_OVF       = 0;
   localparam int PM_FLAG_PERIOD_OK = 1;
   localparam int PM_FLAG_LOST      = 2;
   localparam int PM_FLAG_TIMEOUT   = 3;
   localparam int PM_FLAGS_W        = 4;

   typedef struct packed {
      logic timeout;
      logic lost;
      logic period_ok;
      logic ovf;
   } pm_flags_t;

   function automatic int pm_rec_w(input int cnt_w);
      return 2 * cnt_w + PM_FLAGS_W;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pulse_measure_chan.sv
// ============================================================================
// pulse_measure_chan
// One channel: synchroniser, tick prescalers, width/period counters, record slot.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pulse_measure_chan
   import pulse_measure_multi_pkg::*;
#(
   parameter int  PREDIV      = 2,
   parameter int  MAXV        = 1024,
   parameter int  SYNC_STAGES = 2,
   parameter bit  INV         = 1'b0,
   localparam int CNT_W       = $clog2(MAXV)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_pulse,
   input  logic             i_enable,
   input  logic             i_grant,
   output logic             o_pending,
   output logic             o_alive,
   output logic [CNT_W-1:0] o_width,
   output logic [CNT_W-1:0] o_period,
   output pm_flags_t        o_flags
);
   localparam int               PW         = (PREDIV > 1) ? $clog2(PREDIV) : 1;
   localparam logic [PW-1:0]    c_pre_last = PW'(PREDIV - 1);
   localparam logic [CNT_W-1:0] c_cnt_max  = CNT_W'(MAXV - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_s_d;
   logic [PW-1:0]          r_wpre, r_ppre;
   logic [CNT_W-1:0]       r_width, r_pcnt, r_period;
   logic                   r_pok, r_ovf, r_armed, r_alive, r_pending;
   logic [CNT_W-1:0]       r_rec_width, r_rec_period;
   pm_flags_t              r_rec_flags;

   logic                   w_s, w_rise, w_fall, w_wtick, w_ptick;
   logic                   w_ovf_nx, w_timeout, w_lost;
   logic [CNT_W-1:0]       w_width_nx, w_pcnt_nx;

   // Left unreset so an input already high across reset/enable never fakes a rising edge.
   always_ff @(posedge clk) begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pulse ^ INV};
      r_s_d  <= r_sync[SYNC_STAGES-1];
   end

   always_comb begin
      w_s        = r_sync[SYNC_STAGES-1];
      w_rise     = w_s & ~r_s_d;
      w_fall     = ~w_s & r_s_d;
      w_wtick    = r_s_d && (r_wpre == c_pre_last);
      w_ptick    = (r_ppre == c_pre_last);
      w_width_nx = r_width;
      w_ovf_nx   = r_ovf;
      if (w_wtick) begin
         if (r_width == c_cnt_max) w_ovf_nx = 1'b1;
         else                      w_width_nx = r_width + 1'b1;
      end
      w_pcnt_nx  = (w_ptick && (r_pcnt != c_cnt_max)) ? r_pcnt + 1'b1 : r_pcnt;
      // A pulse still in progress is not a lost signal; it may time out once both samples are low.
      w_timeout  = r_alive && !w_s && !r_s_d && (r_pcnt == c_cnt_max);
      w_lost     = r_pending && !i_grant;
   end

   always_ff @(posedge clk) begin
      if (rst || !i_enable) begin
         r_wpre       <= '0;
         r_ppre       <= '0;
         r_width      <= '0;
         r_pcnt       <= '0;
         r_period     <= '0;
         r_pok        <= 1'b0;
         r_ovf        <= 1'b0;
         r_armed      <= 1'b0;
         r_alive      <= 1'b0;
         r_pending    <= 1'b0;
         r_rec_width  <= '0;
         r_rec_period <= '0;
         r_rec_flags  <= '0;
      end else begin
         r_ppre <= w_ptick ? '0 : r_ppre + 1'b1;
         if (w_rise)     r_wpre <= '0;
         else if (r_s_d) r_wpre <= w_wtick ? '0 : r_wpre + 1'b1;

         if (w_rise) begin
            r_width  <= '0;
            r_ovf    <= 1'b0;
            r_pcnt   <= '0;
            r_period <= r_armed ? w_pcnt_nx : '0;
            r_pok    <= r_armed;
            r_armed  <= 1'b1;
            r_alive  <= 1'b1;
         end else begin
            r_width <= w_width_nx;
            r_ovf   <= w_ovf_nx;
            r_pcnt  <= w_pcnt_nx;
            if (w_timeout) begin
               r_alive <= 1'b0;
               r_armed <= 1'b0;
            end
         end

         if (w_timeout) begin
            r_rec_width  <= '0;
            r_rec_period <= c_cnt_max;
            r_rec_flags  <= '{timeout: 1'b1, lost: w_lost, period_ok: 1'b0, ovf: 1'b0};
            r_pending    <= 1'b1;
         end else if (w_fall && r_armed) begin
            r_rec_width  <= w_width_nx;
            r_rec_period <= r_period;
            r_rec_flags  <= '{timeout: 1'b0, lost: w_lost, period_ok: r_pok, ovf: w_ovf_nx};
            r_pending    <= 1'b1;
         end else if (i_grant) begin
            r_pending <= 1'b0;
         end
      end
   end

   assign o_pending = r_pending;
   assign o_alive   = r_alive;
   assign o_width   = r_rec_width;
   assign o_period  = r_rec_period;
   assign o_flags   = r_rec_flags;

endmodule

`default_nettype wire

// File: rtl/pulse_measure_multi.sv
// ============================================================================
// pulse_measure_multi
// Multi-channel pulse width/period meter; round-robin arbiter onto one stream.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pulse_measure_multi
   import pulse_measure_multi_pkg::*;
#(
   parameter int                  CHANNELS    = 4,
   parameter int                  PREDIV      = 2,
   parameter int                  MAXV        = 1024,
   parameter int                  SYNC_STAGES = 2,
   parameter logic [CHANNELS-1:0] INVERT      = '0,
   localparam int                 CNT_W       = $clog2(MAXV),
   localparam int                 CW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [CHANNELS-1:0]   pulse_in,
   input  logic [CHANNELS-1:0]   ch_enable,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [CW-1:0]         out_chan,
   output logic [CNT_W-1:0]      out_width,
   output logic [CNT_W-1:0]      out_period,
   output logic [PM_FLAGS_W-1:0] out_flags,
   output logic [CHANNELS-1:0]   alive
);
   logic [CHANNELS-1:0] w_pending, w_grant;
   logic [CNT_W-1:0]    w_width  [CHANNELS];
   logic [CNT_W-1:0]    w_period [CHANNELS];
   pm_flags_t           w_flags  [CHANNELS];
   logic [CW-1:0]       w_sel, w_idx;
   logic                w_found, w_load;

   logic                r_valid;
   logic [CW-1:0]       r_chan, r_last;
   logic [CNT_W-1:0]    r_width, r_period;
   pm_flags_t           r_flags;

   generate
      for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
         pulse_measure_chan #(
            .PREDIV      (PREDIV),
            .MAXV        (MAXV),
            .SYNC_STAGES (SYNC_STAGES),
            .INV         (INVERT[g])
         ) u_chan (
            .clk       (clk),
            .rst       (reset),
            .i_pulse   (pulse_in[g]),
            .i_enable  (ch_enable[g]),
            .i_grant   (w_grant[g]),
            .o_pending (w_pending[g]),
            .o_alive   (alive[g]),
            .o_width   (w_width[g]),
            .o_period  (w_period[g]),
            .o_flags   (w_flags[g])
         );
      end
   endgenerate

   // Search starts one past the last granted channel so no channel can starve.
   always_comb begin
      w_load  = !r_valid || out_ready;
      w_found = 1'b0;
      w_sel   = '0;
      w_idx   = '0;
      w_grant = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         w_idx = CW'((int'(r_last) + 1 + k) % CHANNELS);
         if (!w_found && w_pending[w_idx]) begin
            w_found = 1'b1;
            w_sel   = w_idx;
         end
      end
      if (w_found && w_load) w_grant[w_sel] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid  <= 1'b0;
         r_chan   <= '0;
         r_width  <= '0;
         r_period <= '0;
         r_flags  <= '0;
         r_last   <= CW'(CHANNELS - 1);
      end else if (w_load) begin
         r_valid <= w_found;
         if (w_found) begin
            r_chan   <= w_sel;
            r_width  <= w_width[w_sel];
            r_period <= w_period[w_sel];
            r_flags  <= w_flags[w_sel];
            r_last   <= w_sel;
         end
      end
   end

   assign out_valid  = r_valid;
   assign out_chan   = r_chan;
   assign out_width  = r_width;
   assign out_period = r_period;
   assign out_flags  = r_flags;

endmodule

`default_nettype wire

// File: tb/tb_pulse_measure_multi.sv
// ============================================================================
// tb_pulse_measure_multi
// Directed table-driven checks of pulse_measure_multi (4 ch, PREDIV 2, MAXV 16).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pulse_measure_multi;
   import pulse_measure_multi_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] pulse_in = '0;
   logic [3:0] ch_enable = '1;
   logic       out_ready = 1'b1;
   logic       out_valid;
   logic [1:0] out_chan;
   logic [3:0] out_width, out_period, out_flags;
   logic [3:0] alive;

   pulse_measure_multi #(
      .CHANNELS(4), .PREDIV(2), .MAXV(16), .SYNC_STAGES(2), .INVERT(4'b0000)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .pulse_in   (pulse_in),
      .ch_enable  (ch_enable),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_chan   (out_chan),
      .out_width  (out_width),
      .out_period (out_period),
      .out_flags  (out_flags),
      .alive      (alive)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] chan;
      logic [3:0] width;
      logic [3:0] period;
      logic [3:0] flags;
   } rec_t;

   typedef struct {
      int ch;
      int high;
      int exp_w;
      int exp_flags;
      int exp_n;
   } vec_t;

   rec_t q[$];
   int   n_valid = 0;
   int   base = 0;
   int   v0 = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   always @(negedge clk) begin
      if (!reset && out_valid) begin
         n_valid++;
         if (out_ready) q.push_back(rec_t'({out_chan, out_width, out_period, out_flags}));
      end
   end

   function automatic rec_t rec_at(input int i);
      rec_t r = '0;
      if (base + i < q.size()) r = q[base + i];
      return r;
   endfunction

   task automatic chk(input string name, input int act, input int exp_v);
      n_tests++;
      if (act != exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse(input int ch, input int n);
      pulse_in[ch] = 1'b1;
      tick(n);
      pulse_in[ch] = 1'b0;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      pulse_in  = '0;
      ch_enable = '1;
      out_ready = 1'b1;
      tick(4);
      reset = 1'b0;
      base  = q.size();
      v0    = n_valid;
   endtask

   vec_t vt[6];
   rec_t r;
   int   bad;

   initial begin
      // {channel, high clks, width, flags, records (0 = unchecked)}
      vt[0] = '{0, 10, 5,  0, 1};
      vt[1] = '{0, 40, 15, 1, 2};
      vt[2] = '{2, 1,  0,  0, 1};
      vt[3] = '{3, 7,  3,  0, 1};
      vt[4] = '{1, 30, 15, 0, 0};
      vt[5] = '{2, 32, 15, 1, 2};

      do_reset();
      chk("rst_valid",  out_valid,  0);
      chk("rst_chan",   out_chan,   0);
      chk("rst_width",  out_width,  0);
      chk("rst_period", out_period, 0);
      chk("rst_flags",  out_flags,  0);
      chk("rst_alive",  alive,      0);

      for (int i = 0; i < 6; i++) begin
         do_reset();
         pulse(vt[i].ch, vt[i].high);
         tick(10);
         r = rec_at(0);
         if (vt[i].exp_n > 0) begin
            chk($sformatf("vec%0d_count", i), q.size() - base, vt[i].exp_n);
            chk($sformatf("vec%0d_vcycles", i), n_valid - v0, vt[i].exp_n);
         end
         chk($sformatf("vec%0d_chan", i),  r.chan,  vt[i].ch);
         chk($sformatf("vec%0d_width", i), r.width, vt[i].exp_w);
         chk($sformatf("vec%0d_flags", i), r.flags, vt[i].exp_flags);
      end

      // Three armed pulses on ch1: period 20 clk = 10 ticks.
      do_reset();
      for (int p = 0; p < 3; p++) begin
         pulse(1, 6);
         tick(14);
      end
      tick(6);
      chk("train_count", q.size() - base, 3);
      for (int p = 0; p < 3; p++) begin
         r = rec_at(p);
         chk($sformatf("train%0d_chan", p),  r.chan,  1);
         chk($sformatf("train%0d_width", p), r.width, 3);
         chk($sformatf("train%0d_flags", p), r.flags, (p == 0) ? 0 : (1 << PM_FLAG_PERIOD_OK));
         if (p > 0) chk($sformatf("train%0d_period", p), r.period, 10);
      end

      // ch1 and ch2 fall together while the consumer stalls.
      do_reset();
      out_ready = 1'b0;
      pulse_in  = 4'b0110;
      tick(6);
      pulse_in  = 4'b0000;
      tick(5);
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         if (!(out_valid && out_chan == 2'd1 && out_width == 4'd3)) bad++;
         tick(1);
      end
      chk("stall_hold_bad_cycles", bad, 0);
      out_ready = 1'b1;
      tick(4);
      chk("stall_count", q.size() - base, 2);
      chk("stall_first_chan",  rec_at(0).chan, 1);
      chk("stall_second_chan", rec_at(1).chan, 2);
      chk("stall_second_width", rec_at(1).width, 3);

      // Output register occupied by ch0; ch3 overwrites its own pending slot.
      do_reset();
      out_ready = 1'b0;
      pulse(0, 2);
      tick(5);
      ch_enable[0] = 1'b0;
      pulse(3, 8);
      tick(6);
      pulse(3, 8);
      tick(6);
      out_ready = 1'b1;
      tick(6);
      chk("lost_count", q.size() - base, 2);
      chk("lost_held_chan",  rec_at(0).chan,  0);
      chk("lost_held_width", rec_at(0).width, 1);
      chk("lost_chan",   rec_at(1).chan,   3);
      chk("lost_width",  rec_at(1).width,  4);
      chk("lost_period", rec_at(1).period, 7);
      chk("lost_flags",  rec_at(1).flags,  (1 << PM_FLAG_LOST) | (1 << PM_FLAG_PERIOD_OK));
      chk("lost_idle_valid", out_valid, 0);

      // Loss of signal on ch0.
      do_reset();
      pulse(0, 4);
      tick(3);
      chk("alive_after_edge", alive[0], 1);
      tick(40);
      chk("tmo_count",  q.size() - base, 2);
      chk("tmo_chan",   rec_at(1).chan,   0);
      chk("tmo_width",  rec_at(1).width,  0);
      chk("tmo_period", rec_at(1).period, 15);
      chk("tmo_flags",  rec_at(1).flags,  1 << PM_FLAG_TIMEOUT);
      tick(40);
      chk("tmo_no_repeat", q.size() - base, 2);
      chk("tmo_alive", alive[0], 0);

      // Reset in the middle of a pulse with a record stalled in the output register.
      do_reset();
      out_ready = 1'b0;
      pulse(0, 4);
      tick(5);
      chk("mid_pre_valid", out_valid, 1);
      pulse_in[0] = 1'b1;
      tick(4);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      chk("mid_rst_valid", out_valid, 0);
      base = q.size();
      v0   = n_valid;
      out_ready = 1'b1;
      tick(4);
      pulse_in[0] = 1'b0;
      tick(12);
      chk("mid_no_record", q.size() - base, 0);
      chk("mid_no_valid",  n_valid - v0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
